// File: rtl/async_rx_pkg.sv
// Shared definitions for the host-link serial receiver: parity encodings,
// receiver FSM states and elaboration-time helpers.
package async_rx_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } rx_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Rounded accumulator increment; 64-bit so large clocks cannot overflow.
   function automatic longint baud_inc(input longint clk_hz, input longint baud,
                                       input longint oversample, input longint acc_width);
      return ((baud * oversample << (acc_width - 7)) + (clk_hz >> 8)) / (clk_hz >> 7);
   endfunction

endpackage

// File: rtl/async_receiver_fifo_if.sv
// Read-side bus of the receiver: FIFO drain handshake plus status/error pulses.
interface async_receiver_fifo_if
   import async_rx_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int CNT_W = clog2(FIFO_DEPTH + 1);

   logic                 rd_en;
   logic [DATA_BITS-1:0] rd_data;
   logic                 rd_valid;
   logic [CNT_W-1:0]     fifo_count;
   logic                 framing_err;
   logic                 parity_err;
   logic                 overrun_err;
   logic                 idle;
   logic                 endofpacket;

   modport master (
      input  rd_en,
      output rd_data, rd_valid, fifo_count,
      output framing_err, parity_err, overrun_err, idle, endofpacket
   );

   modport slave (
      output rd_en,
      input  rd_data, rd_valid, fifo_count,
      input  framing_err, parity_err, overrun_err, idle, endofpacket
   );
endinterface

// File: rtl/rx_sync_fifo.sv
// First-word-fall-through FIFO; head is combinational, write while full is
// accepted only together with a pop.
module rx_sync_fifo
   import async_rx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_en,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic                        rd_en,
   output logic [WIDTH-1:0]            rd_data,
   output logic                        empty,
   output logic                        full,
   output logic [clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [CW-1:0]    count_q;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr_q] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + AW'(1);
         if (do_rd) rptr_q <= rptr_q + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/async_receiver_fifo.sv
// Oversampling serial receiver with glitch filter, start-bit validation,
// configurable frame format and a FWFT character FIFO.
module async_receiver_fifo
   import async_rx_pkg::*;
#(
   parameter int CLK_HZ     = 80000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 8,
   parameter int ACC_WIDTH  = 18,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = PAR_NONE,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rxd,
   async_receiver_fifo_if.master bus
);
   localparam int CNT_W   = clog2(FIFO_DEPTH + 1);
   localparam int BIT_W   = clog2(OVERSAMPLE);
   localparam int GAP_MAX = 2 * OVERSAMPLE;
   localparam int GAP_W   = clog2(GAP_MAX + 1);
   localparam logic [ACC_WIDTH:0] INC =
      (ACC_WIDTH+1)'(baud_inc(CLK_HZ, BAUD, OVERSAMPLE, ACC_WIDTH));

   logic [ACC_WIDTH:0]   acc_q;
   logic                 tick;
   logic [1:0]           sync_q;
   logic [1:0]           fcnt_q;
   logic                 low_q;
   logic                 line_bit;
   rx_state_e            state_q;
   logic [BIT_W-1:0]     bitcnt_q;
   logic [2:0]           idx_q;
   logic                 stopcnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_bad_q;
   logic                 frm_bad_q;
   logic                 done_q;
   logic                 samp;
   logic                 par_calc;
   logic                 framing_q;
   logic                 parity_q;
   logic                 overrun_q;
   logic [GAP_W-1:0]     gap_q;
   logic                 eop_q;
   logic                 fifo_wr;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic [DATA_BITS-1:0] fifo_head;
   logic [CNT_W-1:0]     fifo_cnt;

   assign tick = acc_q[ACC_WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) acc_q <= '0;
      else       acc_q <= {1'b0, acc_q[ACC_WIDTH-1:0]} + INC;
   end

   // The line is carried inverted so that the cleared state means "line idle".
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         fcnt_q <= '0;
         low_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], ~rxd};
         if (tick) begin
            if (sync_q[1] && fcnt_q != 2'd3)       fcnt_q <= fcnt_q + 2'd1;
            else if (!sync_q[1] && fcnt_q != 2'd0) fcnt_q <= fcnt_q - 2'd1;
            if (fcnt_q == 2'd3)      low_q <= 1'b1;
            else if (fcnt_q == 2'd0) low_q <= 1'b0;
         end
      end
   end

   assign line_bit = ~low_q;
   assign samp     = tick && (bitcnt_q == BIT_W'(OVERSAMPLE - 1));
   assign par_calc = line_bit ^ (^shift_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         bitcnt_q  <= '0;
         idx_q     <= '0;
         stopcnt_q <= 1'b0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
         frm_bad_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (tick) begin
            bitcnt_q <= bitcnt_q + BIT_W'(1);
            case (state_q)
               S_IDLE: begin
                  bitcnt_q <= '0;
                  if (low_q) state_q <= S_START;
               end
               S_START: begin
                  // Mid-start re-check; from here samples land one bit apart.
                  if (bitcnt_q == BIT_W'(OVERSAMPLE/2 - 1)) begin
                     bitcnt_q <= '0;
                     if (!low_q) begin
                        state_q <= S_IDLE;
                     end else begin
                        state_q   <= S_DATA;
                        idx_q     <= '0;
                        par_bad_q <= 1'b0;
                        frm_bad_q <= 1'b0;
                     end
                  end
               end
               S_DATA: begin
                  if (samp) begin
                     shift_q <= {line_bit, shift_q[DATA_BITS-1:1]};
                     idx_q   <= idx_q + 3'd1;
                     if (idx_q == 3'(DATA_BITS - 1)) begin
                        stopcnt_q <= 1'b0;
                        state_q   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                     end
                  end
               end
               S_PARITY: begin
                  if (samp) begin
                     par_bad_q <= (PARITY == PAR_ODD) ? ~par_calc : par_calc;
                     state_q   <= S_STOP;
                  end
               end
               S_STOP: begin
                  if (samp) begin
                     if (!line_bit) frm_bad_q <= 1'b1;
                     stopcnt_q <= 1'b1;
                     if (stopcnt_q == 1'(STOP_BITS - 1)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   // Commit happens in the cycle after the last stop sample.
   assign fifo_wr = done_q && !frm_bad_q && !par_bad_q && (!fifo_full || bus.rd_en);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         framing_q <= 1'b0;
         parity_q  <= 1'b0;
         overrun_q <= 1'b0;
         gap_q     <= '0;
         eop_q     <= 1'b0;
      end else begin
         framing_q <= done_q && frm_bad_q;
         parity_q  <= done_q && !frm_bad_q && par_bad_q;
         overrun_q <= done_q && !frm_bad_q && !par_bad_q && fifo_full && !bus.rd_en;
         eop_q     <= 1'b0;
         if (state_q != S_IDLE) begin
            gap_q <= '0;
         end else if (tick && gap_q != GAP_W'(GAP_MAX)) begin
            gap_q <= gap_q + GAP_W'(1);
            eop_q <= (gap_q == GAP_W'(GAP_MAX - 1));
         end
      end
   end

   rx_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (fifo_wr),
      .wr_data (shift_q),
      .rd_en   (bus.rd_en),
      .rd_data (fifo_head),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_cnt)
   );

   assign bus.rd_data     = fifo_head;
   assign bus.rd_valid    = !fifo_empty;
   assign bus.fifo_count  = fifo_cnt;
   assign bus.framing_err = framing_q;
   assign bus.parity_err  = parity_q;
   assign bus.overrun_err = overrun_q;
   assign bus.idle        = (gap_q == GAP_W'(GAP_MAX));
   assign bus.endofpacket = eop_q;
endmodule

// File: doc/async_receiver_fifo.md
Name: async_receiver_fifo

Overview:
Parametrised successor to the fpga4fun-style serial receiver used by the miner's host link. It adds configurable frame format (data bits, parity, stop bits), configurable oversampling, start-bit validation and explicit error reporting. Received characters go into an on-chip first-word-fall-through FIFO, so the hasher control logic can drain bursts at its own pace. It sits between the RxD pin and the work-loading shift logic.

Parameters:
CLK_HZ, 80000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 8, baud ticks per bit; power of 2, range 4..16
ACC_WIDTH, 18, baud accumulator width
DATA_BITS, 8, data bits per character, range 5..8
PARITY, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, characters buffered; power of 2, minimum 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rxd  in  1  serial line, idle high, asynchronous to clk
rd_en  in  1  pop the head of the FIFO; ignored when empty
rd_data  out  DATA_BITS  FIFO head; valid while rd_valid=1
rd_valid  out  1  FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH+1)  number of characters held
framing_err  out  1  1-cycle pulse: a stop bit was sampled low
parity_err  out  1  1-cycle pulse: parity mismatch
overrun_err  out  1  1-cycle pulse: character dropped because the FIFO was full
idle  out  1  no character activity for 2*OVERSAMPLE ticks
endofpacket  out  1  1-cycle pulse when idle rises

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - All registers clear; state=IDLE; FIFO empty.
  - rd_valid, fifo_count and all pulse outputs are 0; idle=0.
  - Synchroniser and filter clear to the line-idle value (the inverted line is 0), so no phantom character follows reset.
- Baud tick:
  - inc = ((BAUD*OVERSAMPLE << (ACC_WIDTH-7)) + (CLK_HZ>>8)) / (CLK_HZ>>7).
  - acc <= acc[ACC_WIDTH-1:0] + inc; tick = acc[ACC_WIDTH].
  - Computed at elaboration.
- Input conditioning:
  - 2-flop synchroniser on every clk.
  - On each tick: 2-bit saturating counter of the inverted line, with hysteresis. Filtered bit goes to 1 at count 3 and to 0 at count 0.
  - Filter latency is 3-4 ticks.
- FSM (advances only on tick):
  - bitcnt counts ticks within a bit; a bit is sampled when bitcnt==OVERSAMPLE-1.
  - IDLE -> START when the filtered line is low; bitcnt <= 0.
  - START: at tick OVERSAMPLE/2-1 the line is re-checked. If high, return to IDLE as a glitch, with no error. If low, realign bitcnt to mid-bit and go to DATA.
  - DATA: shift LSB first, DATA_BITS samples. Then go to PARITY if PARITY!=0, else STOP.
  - PARITY: one sample, compared against XOR of the data (odd parity inverts the compare).
  - STOP: STOP_BITS samples. Any low sample sets the frame-error flag. After the last stop sample return to IDLE. A new start is detectable on the next tick.
- Character commit (clk cycle after the last stop sample):
  - Framing error: pulse framing_err; no FIFO write.
  - Otherwise, parity mismatch: pulse parity_err; no FIFO write.
  - Otherwise, FIFO full and no rd_en this cycle: pulse overrun_err; character dropped.
  - Otherwise: write to the FIFO.
  - When DATA_BITS<8 the character is right-aligned in rd_data.
- FIFO:
  - rd_data is combinational from the head.
  - rd_en with rd_valid pops at the clock edge.
  - Write and pop in the same cycle: count unchanged, accepted even when full.
  - Pointers wrap modulo FIFO_DEPTH.
- idle / endofpacket:
  - A gap counter clears while state!=IDLE and increments on ticks, saturating at 2*OVERSAMPLE.
  - idle = saturated.
  - endofpacket pulses for 1 clk on the tick that reaches saturation.
- Reset mid-character: the character is discarded and the FIFO is emptied.

Decomposition:
- Package async_rx_pkg:
  - Parity encodings PAR_NONE/PAR_ODD/PAR_EVEN.
  - FSM state enum IDLE/START/DATA/PARITY/STOP.
  - Function computing inc.
  - clog2 helper.
- Sub-module rx_sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Same clk/reset; wr_en, wr_data, rd_en, rd_data, empty, full, count.

Test Plan:
- Config CLK_HZ=1843200, BAUD=115200, OVERSAMPLE=8 (inc=2^17, 16 clk/bit). Send 0xA5 8N1 -> rd_valid rises, rd_data=0xA5, fifo_count=1, no error pulse.
- 8E1 build: send 0x3C with parity 0 -> accepted. Send 0x3D with parity 0 -> parity_err pulse, fifo_count unchanged.
- Send 0x55 with stop bit held low -> framing_err pulse, nothing written. Next 0x12 with good framing is accepted.
- 2-tick low glitch on idle line -> state returns to IDLE, no write, no error.
- FIFO_DEPTH=4: send 5 characters 0x01..0x05 with rd_en=0 -> overrun_err on the 5th, fifo_count=4. Pops return 0x01..0x04 in order.
- 7O2 build, back-to-back 0x41,0x42 followed by silence -> both read correctly. endofpacket pulses once, 16 ticks after the last stop bit. Assert reset mid-character -> FIFO empty, idle=0.
